multi_issue_arbiter: RTL and testbench

MULTI_ISSUE_ARBITER -- requirements
Module: multi_issue_arbiter

---
 rtl/utils.sv | 15 +
 rtl/multi_issue_arbiter_rr_arbiter.sv | 31 +++
 rtl/multi_issue_arbiter.sv | 140 ++++++++++++++
 tb/tb_multi_issue_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utils.sv
// Shared defaults and the CDB reservation-entry type for the multi-issue arbiter.
package multi_issue_arbiter_pkg;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_MAX_LAT = 8;

  // Fixed channel-index width so the entry type is parameter-independent (up to 16 channels).
  localparam int CH_IDX_W = 4;

  typedef struct packed {
    logic                valid;
    logic [CH_IDX_W-1:0] ch;
  } res_entry_t;

endpackage

// File: rtl/multi_issue_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past i_ptr and wraps modulo N.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_grant_valid
);

  logic w_found;

  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    w_found       = 1'b0;
    for (int off = 1; off <= N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (!w_found && i_req[i] && (i == ((int'(i_ptr) + off) % N))) begin
          o_grant[i]  = 1'b1;
          o_grant_idx = IDX_W'(i);
          w_found     = 1'b1;
        end
      end
    end
    o_grant_valid = w_found;
  end

endmodule

// File: rtl/multi_issue_arbiter.sv
// Multi-issue arbiter: issues at most one channel per cycle while reserving a unique
// future CDB slot for each result, so write-back collisions can never happen.
module multi_issue_arbiter
  import multi_issue_arbiter_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int MAX_LAT = DEF_MAX_LAT,
  parameter int LAT_W   = $clog2(MAX_LAT) + 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic [NUM_CH-1:0]       i_ready,
  input  logic [NUM_CH*LAT_W-1:0] i_lat,
  input  logic [NUM_CH-1:0]       i_pipelined,
  output logic [NUM_CH-1:0]       o_issue,
  output logic [NUM_CH-1:0]       o_cdb_sel,
  output logic                    o_cdb_valid,
  output logic [NUM_CH-1:0]       o_busy
);

  res_entry_t          r_res      [MAX_LAT];
  res_entry_t          w_res_next [MAX_LAT];
  logic [LAT_W-1:0]    r_busy_cnt [NUM_CH];
  logic [CH_IDX_W-1:0] r_last_grant;

  logic [LAT_W-1:0]    w_lat       [NUM_CH];
  logic [NUM_CH-1:0]   w_slot_free;
  logic [NUM_CH-1:0]   w_eligible;
  logic [NUM_CH-1:0]   w_grant;
  logic [CH_IDX_W-1:0] w_grant_idx;
  logic                w_grant_valid;
  logic [LAT_W-1:0]    w_grant_lat;

  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      w_lat[n] = i_lat[n*LAT_W +: LAT_W];
    end
  end

  // res[L] pre-shift becomes slot L-1 after the shift; L == MAX_LAT lands in the always-empty top slot.
  always_comb begin
    w_slot_free = '1;
    w_eligible  = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      for (int k = 1; k < MAX_LAT; k++) begin
        if ((int'(w_lat[n]) == k) && r_res[k].valid) begin
          w_slot_free[n] = 1'b0;
        end
      end
      w_eligible[n] = i_ready[n]
                    && (w_lat[n] >= LAT_W'(1))
                    && (w_lat[n] <= LAT_W'(MAX_LAT))
                    && w_slot_free[n]
                    && (r_busy_cnt[n] == '0)
                    && !i_flush
                    && !i_rst;
    end
  end

  rr_arbiter #(
    .N     (NUM_CH),
    .IDX_W (CH_IDX_W)
  ) u_rr_arbiter (
    .i_req         (w_eligible),
    .i_ptr         (r_last_grant),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  assign o_issue = w_grant;

  always_comb begin
    w_grant_lat = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (w_grant[n]) begin
        w_grant_lat = w_lat[n];
      end
    end
  end

  // Shift toward slot 0, then drop the new grant into post-shift slot L-1.
  always_comb begin
    for (int i = 0; i < MAX_LAT; i++) begin
      w_res_next[i] = (i < MAX_LAT - 1) ? r_res[i+1] : '0;
      if (w_grant_valid && (i == int'(w_grant_lat) - 1)) begin
        w_res_next[i].valid = 1'b1;
        w_res_next[i].ch    = w_grant_idx;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < MAX_LAT; i++) begin
        r_res[i] <= '0;
      end
      for (int n = 0; n < NUM_CH; n++) begin
        r_busy_cnt[n] <= '0;
      end
      r_last_grant <= CH_IDX_W'(NUM_CH - 1);
    end else if (i_flush) begin
      for (int i = 0; i < MAX_LAT; i++) begin
        r_res[i] <= '0;
      end
      for (int n = 0; n < NUM_CH; n++) begin
        r_busy_cnt[n] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_LAT; i++) begin
        r_res[i] <= w_res_next[i];
      end
      if (w_grant_valid) begin
        r_last_grant <= w_grant_idx;
      end
      for (int n = 0; n < NUM_CH; n++) begin
        if (w_grant[n] && !i_pipelined[n]) begin
          r_busy_cnt[n] <= w_grant_lat - LAT_W'(1);
        end else if (r_busy_cnt[n] != '0) begin
          r_busy_cnt[n] <= r_busy_cnt[n] - LAT_W'(1);
        end
      end
    end
  end

  assign o_cdb_valid = r_res[0].valid;

  always_comb begin
    o_cdb_sel = '0;
    o_busy    = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (r_res[0].valid && (r_res[0].ch == CH_IDX_W'(n))) begin
        o_cdb_sel[n] = 1'b1;
      end
      o_busy[n] = (r_busy_cnt[n] != '0);
    end
  end

endmodule

// File: tb/tb_multi_issue_arbiter.sv
// Directed bench for multi_issue_arbiter: one task per scenario, inline checks, one summary line.
module tb_multi_issue_arbiter;

  localparam int NUM_CH  = 4;
  localparam int MAX_LAT = 8;
  localparam int LAT_W   = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    flush = 1'b0;
  logic [NUM_CH-1:0]       ready = '0;
  logic [NUM_CH*LAT_W-1:0] lat = '0;
  logic [NUM_CH-1:0]       pipelined = '1;
  logic [NUM_CH-1:0]       issue;
  logic [NUM_CH-1:0]       cdb_sel;
  logic                    cdb_valid;
  logic [NUM_CH-1:0]       busy;

  logic [NUM_CH-1:0]       exp_vec;
  int checks = 0;
  int errors = 0;

  multi_issue_arbiter #(
    .NUM_CH  (NUM_CH),
    .MAX_LAT (MAX_LAT),
    .LAT_W   (LAT_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .i_ready     (ready),
    .i_lat       (lat),
    .i_pipelined (pipelined),
    .o_issue     (issue),
    .o_cdb_sel   (cdb_sel),
    .o_cdb_valid (cdb_valid),
    .o_busy      (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lat(input int n, input int l);
    lat[n*LAT_W +: LAT_W] = LAT_W'(l);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    ready = '0;
    pipelined = '1;
    next_cycle();
    rst = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    ready = 4'b1111;
    for (int n = 0; n < NUM_CH; n++) set_lat(n, 1);
    #1;
    checks++;
    if (issue !== 4'b0000) begin
      errors++; $display("FAIL reset_issue got %b exp %b", issue, 4'b0000);
    end
    next_cycle();
    rst = 1'b0;
    ready = '0;
    #1;
    checks++;
    if (cdb_valid !== 1'b0 || cdb_sel !== 4'b0000 || busy !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got v=%b sel=%b busy=%b exp 0/0000/0000", cdb_valid, cdb_sel, busy);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    do_reset();
    ready = 4'b1111;
    pipelined = 4'b1111;
    for (int n = 0; n < NUM_CH; n++) set_lat(n, 1);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) ready = '0;
      #1;
      exp_vec = (k < 5) ? (4'b0001 << (k % 4)) : 4'b0000;
      checks++;
      if (issue !== exp_vec) begin
        errors++; $display("FAIL rr_issue k=%0d got %b exp %b", k, issue, exp_vec);
      end
      exp_vec = (k == 0) ? 4'b0000 : (4'b0001 << ((k - 1) % 4));
      checks++;
      if (cdb_sel !== exp_vec || cdb_valid !== (k != 0)) begin
        errors++; $display("FAIL rr_cdb k=%0d got sel=%b v=%b exp sel=%b v=%b", k, cdb_sel, cdb_valid, exp_vec, (k != 0));
      end
      next_cycle();
    end
  endtask

  task automatic test_collision();
    do_reset();
    for (int n = 0; n < NUM_CH; n++) set_lat(n, 1);
    set_lat(0, 3);
    set_lat(1, 2);
    ready = 4'b0001;
    #1;
    checks++;
    if (issue !== 4'b0001) begin errors++; $display("FAIL coll_t0 got %b exp %b", issue, 4'b0001); end
    next_cycle();
    ready = 4'b0010;
    #1;
    checks++;
    if (issue !== 4'b0000) begin errors++; $display("FAIL coll_blocked got %b exp %b", issue, 4'b0000); end
    next_cycle();
    #1;
    checks++;
    if (issue !== 4'b0010) begin errors++; $display("FAIL coll_t2 got %b exp %b", issue, 4'b0010); end
    next_cycle();
    ready = '0;
    #1;
    checks++;
    if (cdb_valid !== 1'b1 || cdb_sel !== 4'b0001) begin
      errors++; $display("FAIL coll_cdb_t3 got v=%b sel=%b exp 1/0001", cdb_valid, cdb_sel);
    end
    next_cycle();
    #1;
    checks++;
    if (cdb_valid !== 1'b1 || cdb_sel !== 4'b0010) begin
      errors++; $display("FAIL coll_cdb_t4 got v=%b sel=%b exp 1/0010", cdb_valid, cdb_sel);
    end
    next_cycle();
    #1;
    checks++;
    if (cdb_valid !== 1'b0) begin errors++; $display("FAIL coll_cdb_t5 got %b exp 0", cdb_valid); end
    next_cycle();
  endtask

  task automatic test_nonpipelined();
    do_reset();
    for (int n = 0; n < NUM_CH; n++) set_lat(n, 1);
    set_lat(2, 8);
    pipelined = 4'b1011;
    ready = 4'b0100;
    #1;
    checks++;
    if (issue !== 4'b0100 || busy !== 4'b0000) begin
      errors++; $display("FAIL np_t0 got issue=%b busy=%b exp 0100/0000", issue, busy);
    end
    next_cycle();
    for (int c = 1; c <= 7; c++) begin
      #1;
      checks++;
      if (busy !== 4'b0100 || issue !== 4'b0000 || cdb_valid !== 1'b0) begin
        errors++; $display("FAIL np_busy c=%0d got busy=%b issue=%b v=%b exp 0100/0000/0", c, busy, issue, cdb_valid);
      end
      next_cycle();
    end
    #1;
    checks++;
    if (busy !== 4'b0000 || cdb_valid !== 1'b1 || cdb_sel !== 4'b0100 || issue !== 4'b0100) begin
      errors++; $display("FAIL np_t8 got busy=%b v=%b sel=%b issue=%b exp 0000/1/0100/0100", busy, cdb_valid, cdb_sel, issue);
    end
    next_cycle();
    ready = '0;
    pipelined = '1;
  endtask

  task automatic test_flush();
    do_reset();
    for (int n = 0; n < NUM_CH; n++) set_lat(n, 1);
    set_lat(0, 4);
    ready = 4'b0001;
    #1;
    checks++;
    if (issue !== 4'b0001) begin errors++; $display("FAIL flush_t0 got %b exp %b", issue, 4'b0001); end
    next_cycle();
    flush = 1'b1;
    #1;
    checks++;
    if (issue !== 4'b0000) begin errors++; $display("FAIL flush_issue got %b exp %b", issue, 4'b0000); end
    next_cycle();
    flush = 1'b0;
    ready = '0;
    for (int c = 2; c <= 4; c++) begin
      #1;
      checks++;
      if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_cdb c=%0d got %b exp 0", c, cdb_valid); end
      next_cycle();
    end
    // A result already in slot 0 is still delivered during the flush cycle.
    set_lat(0, 1);
    ready = 4'b0001;
    #1;
    checks++;
    if (issue !== 4'b0001) begin errors++; $display("FAIL flush_regrant got %b exp %b", issue, 4'b0001); end
    next_cycle();
    flush = 1'b1;
    ready = '0;
    #1;
    checks++;
    if (cdb_valid !== 1'b1 || cdb_sel !== 4'b0001) begin
      errors++; $display("FAIL flush_cycle_cdb got v=%b sel=%b exp 1/0001", cdb_valid, cdb_sel);
    end
    next_cycle();
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int n = 0; n < NUM_CH; n++) set_lat(n, 1);
    set_lat(0, 5);
    pipelined = 4'b1110;
    ready = 4'b0001;
    #1;
    checks++;
    if (issue !== 4'b0001) begin errors++; $display("FAIL rstmid_t0 got %b exp %b", issue, 4'b0001); end
    next_cycle();
    rst = 1'b1;
    ready = 4'b1111;
    for (int n = 0; n < NUM_CH; n++) set_lat(n, 2);
    #1;
    checks++;
    if (issue !== 4'b0000 || busy !== 4'b0001) begin
      errors++; $display("FAIL rstmid_t1 got issue=%b busy=%b exp 0000/0001", issue, busy);
    end
    next_cycle();
    rst = 1'b0;
    ready = '0;
    #1;
    checks++;
    if (issue !== 4'b0000 || cdb_valid !== 1'b0 || cdb_sel !== 4'b0000 || busy !== 4'b0000) begin
      errors++; $display("FAIL rstmid_t2 got issue=%b v=%b sel=%b busy=%b exp all 0", issue, cdb_valid, cdb_sel, busy);
    end
    next_cycle();
    ready = 4'b1111;
    #1;
    checks++;
    if (issue !== 4'b0001) begin errors++; $display("FAIL rstmid_first got %b exp %b", issue, 4'b0001); end
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      ready = '0;
      #1;
      checks++;
      if (cdb_valid !== 1'b0 && c != 1) begin
        errors++; $display("FAIL rstmid_stale c=%0d got %b exp 0", c, cdb_valid);
      end
    end
    pipelined = '1;
    next_cycle();
  endtask

  task automatic test_illegal_lat();
    do_reset();
    set_lat(0, 1);
    set_lat(1, 9);
    set_lat(2, 1);
    set_lat(3, 0);
    pipelined = 4'b1111;
    ready = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_vec = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      checks++;
      if (issue !== exp_vec) begin
        errors++; $display("FAIL illegal_issue k=%0d got %b exp %b", k, issue, exp_vec);
      end
      next_cycle();
    end
    ready = '0;
    next_cycle();
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_round_robin();
    test_collision();
    test_nonpipelined();
    test_flush();
    test_reset_mid();
    test_illegal_lat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
